// File: rtl/line_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 line ports around line_arbiter.
// slave is the arbiter's view; master is the surrounding caches and L2.
interface line_arbiter_if;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;

  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;

  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  modport slave (
    input  i_read,
    input  i_address,
    output i_rdata,
    output i_resp,
    input  d_read,
    input  d_write,
    input  d_address,
    input  d_wdata,
    output d_rdata,
    output d_resp,
    output l2_read,
    output l2_write,
    output l2_address,
    output l2_wdata,
    input  l2_rdata,
    input  l2_resp
  );

  modport master (
    output i_read,
    output i_address,
    input  i_rdata,
    input  i_resp,
    output d_read,
    output d_write,
    output d_address,
    output d_wdata,
    input  d_rdata,
    input  d_resp,
    input  l2_read,
    input  l2_write,
    input  l2_address,
    input  l2_wdata,
    output l2_rdata,
    output l2_resp
  );
endinterface

// File: rtl/line_arbiter.sv
// Round-robin arbiter sharing one L2 line port between I-cache and D-cache.
// One transaction at a time; requests are sampled only in IDLE.
module line_arbiter (
  input  logic          clk,
  input  logic          reset,
  line_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           last_grant;
  logic           last_grant_nx;
  logic           op_write;
  logic           op_write_nx;
  logic [15:0]    addr_q;
  logic [15:0]    addr_nx;
  logic [127:0]   wdata_q;
  logic [127:0]   wdata_nx;
  logic [127:0]   line_q;
  logic [127:0]   line_nx;

  logic           i_req;
  logic           d_req;
  logic           grant_any;
  logic           grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Tie goes to the side opposite the last grant (1 = D).
  always_comb begin
    grant_any = 1'b0;
    grant_d   = 1'b0;
    unique case (1'b1)
      (i_req & d_req): begin
        grant_any = 1'b1;
        grant_d   = ~last_grant;
      end
      (i_req & ~d_req): begin
        grant_any = 1'b1;
        grant_d   = 1'b0;
      end
      (~i_req & d_req): begin
        grant_any = 1'b1;
        grant_d   = 1'b1;
      end
      default: begin
        grant_any = 1'b0;
        grant_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    op_write_nx   = op_write;
    addr_nx       = addr_q;
    wdata_nx      = wdata_q;
    line_nx       = line_q;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          state_nx      = grant_d ? SERVE_D : SERVE_I;
          last_grant_nx = grant_d;
          // Read+write together is a write; I side never writes.
          op_write_nx   = grant_d & bus.d_write;
          addr_nx       = grant_d ? bus.d_address
                                  : bus.i_address;
          if (grant_d && bus.d_write) begin
            wdata_nx = bus.d_wdata;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.l2_resp) begin
          line_nx  = bus.l2_rdata;
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      op_write   <= op_write_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      line_q     <= line_nx;
    end
  end

  assign bus.l2_read    = (state == SERVE_I) |
                          ((state == SERVE_D) & ~op_write);
  assign bus.l2_write   = (state == SERVE_D) & op_write;
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;

  assign bus.i_rdata = line_q;
  assign bus.d_rdata = line_q;
  assign bus.i_resp  = (state == RESP) & ~last_grant;
  assign bus.d_resp  = (state == RESP) & last_grant;

endmodule

// File: tb/tb_line_arbiter.sv
// Directed bench for line_arbiter: drives the line ports cycle by cycle
// and checks hand-computed L2 and response values.
module tb_line_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  line_arbiter_if bus ();

  line_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LINE_A = {16{8'hAA}};
  localparam logic [127:0] WB_D   =
    128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] R1 = {4{32'h1111_0001}};
  localparam logic [127:0] R2 = {4{32'h2222_0002}};
  localparam logic [127:0] R3 = {4{32'h3333_0003}};
  localparam logic [127:0] R4 = {4{32'h4444_0004}};
  localparam logic [127:0] R5 = {4{32'h5555_0005}};
  localparam logic [127:0] R6 = {4{32'h6666_0006}};
  localparam logic [127:0] R7 = {4{32'h7777_0007}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".l2_read"},  128'(bus.l2_read),  128'd0);
    chk({tag, ".l2_write"}, 128'(bus.l2_write), 128'd0);
    chk({tag, ".i_resp"},   128'(bus.i_resp),   128'd0);
    chk({tag, ".d_resp"},   128'(bus.d_resp),   128'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.l2_rdata  = '0;
    bus.l2_resp   = 1'b0;
    step();
    step();
    chk_idle_outs("rst");
    chk("rst.i_rdata",    bus.i_rdata,           128'd0);
    chk("rst.d_rdata",    bus.d_rdata,           128'd0);
    chk("rst.l2_address", 128'(bus.l2_address),  128'd0);
    reset = 1'b0;
    step();

    // I-only read, L2 answers three cycles after the grant
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1230;
    step();
    chk("ird.l2_read",    128'(bus.l2_read),    128'd1);
    chk("ird.l2_write",   128'(bus.l2_write),   128'd0);
    chk("ird.l2_address", 128'(bus.l2_address), 128'h1230);
    step();
    step();
    chk("ird.l2_read_held", 128'(bus.l2_read), 128'd1);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = LINE_A;
    step();
    bus.l2_resp  = 1'b0;
    bus.l2_rdata = '0;
    chk("ird.i_resp",  128'(bus.i_resp),  128'd1);
    chk("ird.d_resp",  128'(bus.d_resp),  128'd0);
    chk("ird.i_rdata", bus.i_rdata,       LINE_A);
    chk("ird.l2_read_drop", 128'(bus.l2_read), 128'd0);
    bus.i_read = 1'b0;
    step();
    chk_idle_outs("ird.after");

    // D write-back
    bus.d_write   = 1'b1;
    bus.d_address = 16'h4560;
    bus.d_wdata   = WB_D;
    step();
    chk("dwb.l2_write",   128'(bus.l2_write),   128'd1);
    chk("dwb.l2_read",    128'(bus.l2_read),    128'd0);
    chk("dwb.l2_address", 128'(bus.l2_address), 128'h4560);
    chk("dwb.l2_wdata",   bus.l2_wdata,         WB_D);
    step();
    chk("dwb.l2_wdata_held", bus.l2_wdata, WB_D);
    bus.l2_resp = 1'b1;
    step();
    bus.l2_resp = 1'b0;
    chk("dwb.d_resp",   128'(bus.d_resp),   128'd1);
    chk("dwb.i_resp",   128'(bus.i_resp),   128'd0);
    chk("dwb.l2_write_drop", 128'(bus.l2_write), 128'd0);
    bus.d_write = 1'b0;
    bus.d_wdata = '0;
    step();
    chk_idle_outs("dwb.after");

    // Simultaneous reads straight after reset: I wins the first tie
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1110;
    bus.d_read    = 1'b1;
    bus.d_address = 16'h2220;
    step();
    chk("tie1.l2_address", 128'(bus.l2_address), 128'h1110);
    chk("tie1.l2_read",    128'(bus.l2_read),    128'd1);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R1;
    step();
    bus.l2_resp = 1'b0;
    chk("tie1.i_resp",  128'(bus.i_resp), 128'd1);
    chk("tie1.d_resp",  128'(bus.d_resp), 128'd0);
    chk("tie1.i_rdata", bus.i_rdata,      R1);
    bus.i_read = 1'b0;
    step();
    chk_idle_outs("tie1.gap");
    step();
    chk("tie1.d_address", 128'(bus.l2_address), 128'h2220);
    chk("tie1.d_l2_read", 128'(bus.l2_read),    128'd1);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R2;
    step();
    bus.l2_resp = 1'b0;
    chk("tie1.d_resp2",  128'(bus.d_resp), 128'd1);
    chk("tie1.i_resp2",  128'(bus.i_resp), 128'd0);
    chk("tie1.d_rdata",  bus.d_rdata,      R2);
    bus.d_read = 1'b0;
    step();

    // Next tie: last grant was D, so I first; I re-requests in RESP
    bus.i_read    = 1'b1;
    bus.i_address = 16'h3330;
    bus.d_read    = 1'b1;
    bus.d_address = 16'h4440;
    step();
    chk("tie2.first", 128'(bus.l2_address), 128'h3330);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R3;
    step();
    bus.l2_resp = 1'b0;
    chk("tie2.i_resp", 128'(bus.i_resp), 128'd1);
    bus.i_address = 16'h5550;
    step();
    step();
    chk("tie2.second", 128'(bus.l2_address), 128'h4440);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R4;
    step();
    bus.l2_resp = 1'b0;
    chk("tie2.d_resp", 128'(bus.d_resp), 128'd1);
    chk("tie2.d_rdata", bus.d_rdata, R4);
    bus.d_read = 1'b0;
    step();
    step();
    chk("tie2.third", 128'(bus.l2_address), 128'h5550);
    chk("tie2.third_rd", 128'(bus.l2_read), 128'd1);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R5;
    step();
    bus.l2_resp = 1'b0;
    chk("tie2.i_resp3", 128'(bus.i_resp), 128'd1);
    bus.i_read = 1'b0;
    step();

    // Read and write together act as a write; requester drops early
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 16'h7770;
    bus.d_wdata   = R6;
    step();
    chk("rw.l2_write", 128'(bus.l2_write), 128'd1);
    chk("rw.l2_read",  128'(bus.l2_read),  128'd0);
    chk("rw.l2_wdata", bus.l2_wdata,       R6);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    step();
    chk("rw.held", 128'(bus.l2_write), 128'd1);
    bus.l2_resp = 1'b1;
    step();
    bus.l2_resp = 1'b0;
    chk("rw.d_resp", 128'(bus.d_resp), 128'd1);
    step();

    // Reset while SERVE_D waits on L2
    bus.d_read    = 1'b1;
    bus.d_address = 16'h5550;
    step();
    chk("rst2.l2_read_pre", 128'(bus.l2_read), 128'd1);
    reset      = 1'b1;
    bus.d_read = 1'b0;
    step();
    chk("rst2.l2_read", 128'(bus.l2_read), 128'd0);
    reset        = 1'b0;
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R7;
    step();
    bus.l2_resp = 1'b0;
    chk_idle_outs("rst2.late");
    step();
    chk_idle_outs("rst2.after");
    chk("rst2.d_rdata", bus.d_rdata, 128'd0);

    // Back-to-back D reads
    bus.d_read    = 1'b1;
    bus.d_address = 16'h0100;
    step();
    chk("b2b.addr1", 128'(bus.l2_address), 128'h0100);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R1;
    step();
    bus.l2_resp = 1'b0;
    chk("b2b.resp1", 128'(bus.d_resp), 128'd1);
    bus.d_read = 1'b0;
    step();
    chk("b2b.gap", 128'(bus.d_resp), 128'd0);
    bus.d_read    = 1'b1;
    bus.d_address = 16'h0200;
    step();
    chk("b2b.addr2", 128'(bus.l2_address), 128'h0200);
    chk("b2b.rd2",   128'(bus.l2_read),    128'd1);
    chk("b2b.noresp", 128'(bus.d_resp),    128'd0);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = R2;
    step();
    bus.l2_resp = 1'b0;
    chk("b2b.resp2",  128'(bus.d_resp), 128'd1);
    chk("b2b.rdata2", bus.d_rdata,      R2);
    bus.d_read = 1'b0;
    step();
    chk_idle_outs("b2b.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
